// File: rtl/button_debounce_multi_pkg.sv
// Shared timing defaults (12 MHz hwclk) and the auto-repeat state encoding
// for the multi-channel button debouncer.
package btn_pkg;

   localparam int DEB_10MS   = 120000;
   localparam int HOLD_500MS = 6000000;
   localparam int REP_100MS  = 1200000;

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      HOLD     = 2'd1,
      REPEAT   = 2'd2
   } rpt_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_debounce_multi_if.sv
// Button bundle between the pad ring (master side drives btn_raw) and the
// debouncer (slave side returns the filtered level and event strobes).
interface button_debounce_multi_if #(
   parameter int NUM_CH = 4
) ();

   logic [NUM_CH-1:0] btn_raw;
   logic [NUM_CH-1:0] btn_level;
   logic [NUM_CH-1:0] btn_press;
   logic [NUM_CH-1:0] btn_release;
   logic [NUM_CH-1:0] btn_repeat;
   logic [NUM_CH-1:0] btn_toggle;

   modport master (
      output btn_raw,
      input  btn_level, btn_press, btn_release, btn_repeat, btn_toggle
   );

   modport slave (
      input  btn_raw,
      output btn_level, btn_press, btn_release, btn_repeat, btn_toggle
   );

endinterface

// File: rtl/button_debounce_multi_channel.sv
// One button: 2-FF synchroniser, symmetric stable-time filter, press/release
// strobes, toggle latch and optional auto-repeat.
//
//   state    | meaning
//   RELEASED | button not accepted as pressed, no repeat timing
//   HOLD     | pressed, timing the initial hold delay
//   REPEAT   | pressed past the hold delay, timing repeat intervals
module debounce_channel
   import btn_pkg::*;
#(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = DEB_10MS,
   parameter int REPEAT_EN       = 0,
   parameter int HOLD_CYCLES     = HOLD_500MS,
   parameter int REPEAT_CYCLES   = REP_100MS
) (
   input  logic hwclk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press_stb,
   output logic release_stb,
   output logic repeat_stb,
   output logic toggle
);

   localparam int             MW       = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [MW-1:0]  M_TC     = MW'(DEBOUNCE_CYCLES - 1);
   localparam logic           IDLE_LVL = (ACTIVE_LOW != 0);

   logic [1:0]    sync;
   logic          p_sync;
   logic [MW-1:0] mis;
   logic          accept;

   // Sync chain resets to the released pad level so reset release is silent.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) sync <= {2{IDLE_LVL}};
      else        sync <= {sync[0], raw};
   end

   assign p_sync = sync[1] ^ IDLE_LVL;
   assign accept = (p_sync != level) && (mis == M_TC);

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         level       <= 1'b0;
         mis         <= '0;
         press_stb   <= 1'b0;
         release_stb <= 1'b0;
         toggle      <= 1'b0;
      end else begin
         press_stb   <= 1'b0;
         release_stb <= 1'b0;
         if (p_sync == level) begin
            mis <= '0;
         end else if (accept) begin
            level       <= p_sync;
            mis         <= '0;
            press_stb   <= p_sync;
            release_stb <= ~p_sync;
            toggle      <= toggle ^ p_sync;
         end else begin
            mis <= mis + MW'(1);
         end
      end
   end

   if (REPEAT_EN != 0) begin : g_rpt
      localparam int            RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int            RW   = cnt_w(RMAX);
      localparam logic [RW-1:0] H_TC = RW'(HOLD_CYCLES - 1);
      localparam logic [RW-1:0] R_TC = RW'(REPEAT_CYCLES - 1);

      rpt_state_t    state;
      logic [RW-1:0] r;
      logic          rpt;

      // An accepted release beats a repeat falling due in the same cycle.
      always_ff @(posedge hwclk or negedge rst_n) begin
         if (!rst_n) begin
            state <= RELEASED;
            r     <= '0;
            rpt   <= 1'b0;
         end else begin
            rpt <= 1'b0;
            case (state)
               RELEASED: begin
                  if (accept && p_sync) begin
                     state <= HOLD;
                     r     <= '0;
                  end
               end
               HOLD: begin
                  if (accept && !p_sync) begin
                     state <= RELEASED;
                     r     <= '0;
                  end else if (r == H_TC) begin
                     state <= REPEAT;
                     r     <= '0;
                     rpt   <= 1'b1;
                  end else begin
                     r <= r + RW'(1);
                  end
               end
               REPEAT: begin
                  if (accept && !p_sync) begin
                     state <= RELEASED;
                     r     <= '0;
                  end else if (r == R_TC) begin
                     r   <= '0;
                     rpt <= 1'b1;
                  end else begin
                     r <= r + RW'(1);
                  end
               end
               default: begin
                  state <= RELEASED;
                  r     <= '0;
               end
            endcase
         end
      end

      assign repeat_stb = rpt;
   end else begin : g_no_rpt
      assign repeat_stb = 1'b0;
   end

endmodule

// File: rtl/button_debounce_multi.sv
// N independent debounce channels between the pull-up pads and the
// application logic.
module button_debounce_multi
   import btn_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = DEB_10MS,
   parameter int REPEAT_EN       = 0,
   parameter int HOLD_CYCLES     = HOLD_500MS,
   parameter int REPEAT_CYCLES   = REP_100MS
) (
   input logic                      hwclk,
   input logic                      rst_n,
   button_debounce_multi_if.slave   bus
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .hwclk       (hwclk),
         .rst_n       (rst_n),
         .raw         (bus.btn_raw[i]),
         .level       (bus.btn_level[i]),
         .press_stb   (bus.btn_press[i]),
         .release_stb (bus.btn_release[i]),
         .repeat_stb  (bus.btn_repeat[i]),
         .toggle      (bus.btn_toggle[i])
      );
   end

endmodule
